// File: rtl/diff_pkg.sv
// ----------------------------------------------------------------------------
// diff_pkg
// Shared definitions for the DIFF scan unit: FSM state encodings, scan-mode
// constants and a small width helper used for derived parameters.
// ----------------------------------------------------------------------------
package diff_pkg;

   // FSM state encodings
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Scan direction: first differing bit from the LSB or from the MSB
   localparam logic MODE_LSB = 1'b0;
   localparam logic MODE_MSB = 1'b1;

   // $clog2 that never returns 0, so a 1-entry index still gets a 1-bit field
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : diff_pkg

// File: rtl/diff_chunk_penc.sv
// ----------------------------------------------------------------------------
// diff_chunk_penc
// Combinational priority encoder over one CHUNK-bit slice of the XOR word.
//
// Ports
//   chunk_i   in   CHUNK  slice of X = A ^ B being examined
//   dir_i     in   1      MODE_LSB: lowest set bit wins, MODE_MSB: highest wins
//   hit_o     out  1      at least one bit of the slice is set
//   offset_o  out  OW     bit offset of the winning bit inside the slice
//                         (0 when hit_o = 0)
// ----------------------------------------------------------------------------
module diff_chunk_penc
   import diff_pkg::*;
#(
   parameter  int CHUNK = 8,
   localparam int OW    = clog2_min1(CHUNK)
) (
   input  logic [CHUNK-1:0] chunk_i,
   input  logic             dir_i,
   output logic             hit_o,
   output logic [OW-1:0]    offset_o
);

   // NOTE: every output gets a default before the loops so no path leaves
   // it unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      hit_o    = |chunk_i;
      offset_o = '0;
      if (dir_i == MODE_MSB) begin
         // Ascending walk: the last set bit seen is the highest one
         for (int i = 0; i < CHUNK; i++) begin
            if (chunk_i[i]) offset_o = OW'(i);
         end
      end else begin
         // Descending walk: the last set bit seen is the lowest one
         for (int i = CHUNK - 1; i >= 0; i--) begin
            if (chunk_i[i]) offset_o = OW'(i);
         end
      end
   end

endmodule : diff_chunk_penc

// File: rtl/diff_scan_unit.sv
// ----------------------------------------------------------------------------
// diff_scan_unit
// Multi-cycle DIFF unit for the KGP-miniRISC ALU. Captures X = A ^ B on
// accept and scans it CHUNK bits per cycle, from the LSB end or the MSB end,
// stopping at the first chunk that contains a set bit. Reports whether the
// operands differ and the index of the first differing bit.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      request valid
//   in_ready   out  1      unit idle and able to accept a request
//   A, B       in   WIDTH  operands, sampled on accept
//   mode       in   1      0: first differing bit from LSB, 1: from MSB
//   out_valid  out  1      result valid, held until out_ready
//   out_ready  in   1      consumer takes the result
//   found      out  1      A != B
//   pos        out  PW     index of first differing bit, 0 when found = 0
//
// Timing: a request accepted at edge t whose hit lies in scan step k raises
// out_valid at edge t+2+k. The result registers are loaded on the edge that
// enters DONE; out_valid follows on the next edge, so the consumer always
// sees found/pos that have already been stable for a full cycle.
// ----------------------------------------------------------------------------
module diff_scan_unit
   import diff_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int CHUNK = 8,
   localparam int PW    = clog2_min1(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             found,
   output logic [PW-1:0]    pos
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int KW     = clog2_min1(NCHUNK);
   localparam int OW     = clog2_min1(CHUNK);

   localparam logic [KW-1:0] K_LAST   = KW'(NCHUNK - 1);
   localparam logic [PW-1:0] CHUNK_PW = PW'(CHUNK);

   // Parameter sanity, evaluated at elaboration
   if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_params
      $error("diff_scan_unit: WIDTH must be a positive multiple of CHUNK");
   end

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_e           state_q;
   logic [WIDTH-1:0] x_q;
   logic             mode_q;
   logic [KW-1:0]    k_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             found_q;
   logic [PW-1:0]    pos_q;

   // ------------------------------------------------------------------------
   // Chunk selection and in-chunk encode
   // ------------------------------------------------------------------------
   logic [KW-1:0]    c_idx;
   logic [CHUNK-1:0] chunk_bits;
   logic             chunk_hit;
   logic [OW-1:0]    chunk_off;
   logic [PW-1:0]    pos_d;

   // MSB mode walks the chunks top-down, so chunk c = NCHUNK-1-k
   assign c_idx      = (mode_q == MODE_MSB) ? (K_LAST - k_q) : k_q;
   assign chunk_bits = x_q[int'(c_idx) * CHUNK +: CHUNK];

   diff_chunk_penc #(
      .CHUNK (CHUNK)
   ) u_penc (
      .chunk_i  (chunk_bits),
      .dir_i    (mode_q),
      .hit_o    (chunk_hit),
      .offset_o (chunk_off)
   );

   // c*CHUNK + offset is always below WIDTH, so PW bits never overflow
   assign pos_d = (PW'(c_idx) * CHUNK_PW) + PW'(chunk_off);

   // ------------------------------------------------------------------------
   // FSM with registered outputs
   // ------------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // Reset aborts any scan in flight and discards a pending result
         state_q     <= ST_IDLE;
         x_q         <= '0;
         mode_q      <= MODE_LSB;
         k_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         found_q     <= 1'b0;
         pos_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready_q) begin
                  x_q        <= A ^ B;
                  mode_q     <= mode;
                  k_q        <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_SCAN;
               end
            end

            ST_SCAN: begin
               if (chunk_hit) begin
                  found_q <= 1'b1;
                  pos_q   <= pos_d;
                  state_q <= ST_DONE;
               end else if (k_q == K_LAST) begin
                  found_q <= 1'b0;
                  pos_q   <= '0;
                  state_q <= ST_DONE;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end

            ST_DONE: begin
               // First DONE cycle only raises out_valid; afterwards wait for
               // the consumer. in_ready stays low here, so no request can be
               // taken on the edge that retires the result.
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end

            default: begin
               state_q     <= ST_IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign found     = found_q;
   assign pos       = pos_q;

endmodule : diff_scan_unit

// File: tb/tb_diff_scan_unit.sv
// ----------------------------------------------------------------------------
// tb_diff_scan_unit
// Scoreboard bench for diff_scan_unit (WIDTH=32, CHUNK=8). The stimulus
// process pushes the model's expected result (found, pos, accept edge,
// latency) when a request is accepted; a monitor pops and compares whenever
// out_valid rises and checks that held results stay stable.
// ----------------------------------------------------------------------------
module tb_diff_scan_unit;

   localparam int WIDTH  = 32;
   localparam int CHUNK  = 8;
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int PW     = $clog2(WIDTH);
   localparam int NRAND  = 4000;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             mode = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic             found;
   logic [PW-1:0]    pos;

   diff_scan_unit #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (a),
      .B         (b),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .found     (found),
      .pos       (pos)
   );

   always #5 clk = ~clk;

   // Edge counter: at a negedge, cyc equals the number of the last posedge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: plain bit search on X = A ^ B
   // ------------------------------------------------------------------------
   typedef struct {
      logic          found;
      logic [PW-1:0] pos;
      int            t;
      int            lat;
   } exp_t;

   exp_t exp_q[$];

   function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                  input logic mv);
      exp_t             r;
      logic [WIDTH-1:0] x;
      int               p;
      x       = av ^ bv;
      r.t     = 0;
      r.found = 1'b0;
      r.pos   = '0;
      r.lat   = NCHUNK + 1;
      if (x != 0) begin
         if (!mv) begin
            p = 0;
            while (!x[p]) p++;
            r.lat = 2 + p / CHUNK;
         end else begin
            p = WIDTH - 1;
            while (!x[p]) p--;
            r.lat = 2 + (NCHUNK - 1 - p / CHUNK);
         end
         r.found = 1'b1;
         r.pos   = PW'(p);
      end
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // out_ready driver: 0 = always ready, 1 = random, 2 = held low
   // ------------------------------------------------------------------------
   int rdy_mode = 0;
   initial begin
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(3) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------------
   int            last_hs = -100;
   logic          prev_v  = 1'b0;
   logic          f_cap   = 1'b0;
   logic [PW-1:0] p_cap   = '0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v = 1'b0;
         end else begin
            if (out_valid === 1'b1 && !prev_v) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_out_valid", out_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("found", found, e.found);
                  check("pos", pos, e.pos);
                  check("latency", cyc - e.t, e.lat);
               end
               f_cap = found;
               p_cap = pos;
            end else if (out_valid === 1'b1 && prev_v) begin
               check("held_found", found, f_cap);
               check("held_pos", pos, p_cap);
            end
            if (out_valid === 1'b1) check("in_ready_while_valid", in_ready, 0);
            if (out_valid === 1'b1 && out_ready) last_hs = cyc + 1;
            prev_v = (out_valid === 1'b1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers (called at a negedge, return at a negedge)
   // ------------------------------------------------------------------------
   task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic mv);
      exp_t e;
      bit   ok;
      ok       = 1'b0;
      a        = av;
      b        = bv;
      mode     = mv;
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         check("accept_timeout", in_ready, 1);
         in_valid = 1'b0;
         return;
      end
      e   = model(av, bv, mv);
      e.t = cyc + 1;
      exp_q.push_back(e);
      check("no_bypass_accept", (e.t > last_hs), 1);
      @(negedge clk);
      // Scramble inputs after accept: only the captured copies may matter
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      mode     = 1'($urandom_range(1));
   endtask

   task automatic wait_valid(input int limit);
      for (int i = 0; i < limit; i++) begin
         if (out_valid === 1'b1) break;
         @(negedge clk);
      end
   endtask

   function automatic logic [WIDTH-1:0] rand_x();
      logic [WIDTH-1:0] x;
      case ($urandom_range(3))
         0: x = '0;
         1: x = WIDTH'(1) << $urandom_range(WIDTH - 1);
         2: begin
            x = $urandom;
            for (int c = 0; c < NCHUNK; c++)
               if ($urandom_range(1) == 0) x[c*CHUNK +: CHUNK] = '0;
         end
         default: x = $urandom;
      endcase
      return x;
   endfunction

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rx;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_found", found, 0);
      check("rst_pos", pos, 0);
      rst = 1'b0;

      // Directed cases
      issue(32'd63, 32'd96, 1'b0);
      issue(32'd63, 32'd96, 1'b1);
      issue(32'd4, 32'd8, 1'b0);
      issue(32'd4, 32'd8, 1'b1);
      issue(32'd4, 32'd4, 1'b0);
      issue(32'd4, 32'd4, 1'b1);
      issue(32'h8000_0000, 32'd0, 1'b0);
      issue(32'h0000_0001, 32'd0, 1'b1);

      // Backpressure with a second request waiting
      wait_valid(50);
      while (out_valid === 1'b1) @(negedge clk);
      rdy_mode = 2;
      issue(32'd4, 32'd8, 1'b0);
      wait_valid(20);
      check("bp_out_valid_up", out_valid, 1);
      a        = 32'd5;
      b        = 32'd5;
      mode     = 1'b1;
      in_valid = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("bp_in_ready_low", in_ready, 0);
         check("bp_out_valid_held", out_valid, 1);
      end
      rdy_mode = 0;
      issue(32'd5, 32'd5, 1'b1);

      // Reset in the middle of a scan
      wait_valid(50);
      while (out_valid === 1'b1) @(negedge clk);
      issue(32'h8000_0000, 32'd0, 1'b0);
      void'(exp_q.pop_back());
      @(negedge clk);
      check("pre_rst_scanning", in_ready, 0);
      rst = 1'b1;
      @(negedge clk);
      check("midscan_rst_in_ready", in_ready, 1);
      check("midscan_rst_out_valid", out_valid, 0);
      check("midscan_rst_found", found, 0);
      check("midscan_rst_pos", pos, 0);
      rst = 1'b0;
      issue(32'd1, 32'd0, 1'b0);

      // Random sweep with random backpressure
      rdy_mode = 1;
      for (int n = 0; n < NRAND; n++) begin
         ra = $urandom;
         rx = rand_x();
         issue(ra, ra ^ rx, 1'($urandom_range(1)));
      end
      rdy_mode = 0;

      // Drain outstanding results
      for (int i = 0; i < 500; i++) begin
         if (exp_q.size() == 0 && out_valid !== 1'b1) break;
         @(negedge clk);
      end
      check("drain_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

endmodule : tb_diff_scan_unit
